// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target
// Contents:
//   i2c_state_e  4-bit FSM state encoding (0..7)
//   RW_READ/RW_WRITE  address-byte R/W bit values
//   ACK/NACK  bus level of the acknowledge bit
//   maj3  three-input majority vote used by the optional line filter
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_RX_DATA   = 4'd3,
    ST_RX_ACK    = 4'd4,
    ST_TX_DATA   = 4'd5,
    ST_TX_ACK    = 4'd6,
    ST_WAIT_STOP = 4'd7
  } i2c_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer, optional glitch filter, edge and START/STOP detect
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   scl_in, sda_in  raw bus lines
//   scl_rise/scl_fall  one-cycle SCL edge strobes
//   start_det/stop_det one-cycle START/STOP strobes
//   sda_s           conditioned SDA level
// Macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizer.
module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_c;
  logic                   sda_c;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  // Reset to the idle bus level so no phantom edge appears after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_win_q;
  logic [1:0] sda_win_q;
  logic       scl_filt_q;
  logic       sda_filt_q;

  // Vote over the current synced sample and the two before it: a level
  // present for a single clk never wins the majority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_win_q  <= 2'b11;
      sda_win_q  <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_win_q  <= {scl_win_q[0], scl_sync_q[SYNC_STAGES-1]};
      sda_win_q  <= {sda_win_q[0], sda_sync_q[SYNC_STAGES-1]};
      scl_filt_q <= maj3(scl_sync_q[SYNC_STAGES-1], scl_win_q[0], scl_win_q[1]);
      sda_filt_q <= maj3(sda_sync_q[SYNC_STAGES-1], sda_win_q[0], sda_win_q[1]);
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[SYNC_STAGES-1];
  assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  // SDA may only change while SCL is low; a change with SCL held high is a bus condition.
  assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;
  assign sda_s     = sda_c;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - fixed-address I2C target with byte rx/tx ports, no clock stretching
// Ports:
//   clk, rst           system clock (>= 8x SCL), synchronous active-low reset
//   scl_in, sda_in     raw bus lines
//   sda_out            open-drain drive, 0 = pull low, 1 = release
//   rx_data/rx_valid   last written byte and its one-cycle strobe
//   tx_data/tx_ack     byte for the next read and its one-cycle latch strobe
//   addressed          high from matching address ACK until STOP/START
//   state              current FSM state
// Macro I2C_SLAVE_GLITCH_FILTER_EN enables the line glitch filter in i2c_line_sync.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h2D,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       addressed,
  output logic [3:0] state
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       byte_done_q;   // 8th rise seen, waiting for the fall that opens the ACK slot
  logic       mack_q;        // master's ACK bit after a read byte
  logic       sda_out_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_ack_q;
  logic       addressed_q;

  logic [7:0] shift_d;
  logic [2:0] bit_cnt_d;
  logic       byte_end;

  assign shift_d   = {shift_q[6:0], sda_s};
  assign bit_cnt_d = bit_cnt_q + 3'd1;
  assign byte_end  = (bit_cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_done_q <= 1'b0;
      mack_q      <= NACK;
      sda_out_q   <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_ack_q    <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_ack_q   <= 1'b0;
      if (start_det) begin
        state_q     <= ST_ADDR;
        bit_cnt_q   <= 3'd0;
        shift_q     <= 8'h00;
        byte_done_q <= 1'b0;
        sda_out_q   <= 1'b1;
        addressed_q <= 1'b0;
      end else if (stop_det) begin
        state_q     <= ST_IDLE;
        byte_done_q <= 1'b0;
        sda_out_q   <= 1'b1;
        addressed_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_ADDR: begin
            if (scl_rise && !byte_done_q) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_d;
              if (byte_end) begin
                if (shift_d[7:1] == SLAVE_ADDR) byte_done_q <= 1'b1;
                else                            state_q     <= ST_WAIT_STOP;
              end
            end else if (scl_fall && byte_done_q) begin
              byte_done_q <= 1'b0;
              sda_out_q   <= ACK;
              addressed_q <= 1'b1;
              state_q     <= ST_ADDR_ACK;
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 3'd0;
              if (shift_q[0] == RW_READ) begin
                shift_q   <= tx_data;
                sda_out_q <= tx_data[7];
                tx_ack_q  <= 1'b1;
                state_q   <= ST_TX_DATA;
              end else begin
                sda_out_q <= 1'b1;
                state_q   <= ST_RX_DATA;
              end
            end
          end
          ST_RX_DATA: begin
            if (scl_rise && !byte_done_q) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_d;
              if (byte_end) begin
                rx_data_q   <= shift_d;
                rx_valid_q  <= 1'b1;
                byte_done_q <= 1'b1;
              end
            end else if (scl_fall && byte_done_q) begin
              byte_done_q <= 1'b0;
              sda_out_q   <= ACK;
              state_q     <= ST_RX_ACK;
            end
          end
          ST_RX_ACK: begin
            if (scl_fall) begin
              sda_out_q <= 1'b1;
              bit_cnt_q <= 3'd0;
              state_q   <= ST_RX_DATA;
            end
          end
          ST_TX_DATA: begin
            // Bit 7 is already on the bus; each fall presents the next bit
            // until bit 0 has had its clock, then the line is freed for the ACK.
            if (scl_fall) begin
              if (byte_end) begin
                sda_out_q <= 1'b1;
                bit_cnt_q <= 3'd0;
                state_q   <= ST_TX_ACK;
              end else begin
                shift_q   <= {shift_q[6:0], shift_q[7]};
                sda_out_q <= shift_q[6];
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_rise) begin
              mack_q <= sda_s;
            end else if (scl_fall) begin
              bit_cnt_q <= 3'd0;
              if (mack_q == ACK) begin
                shift_q   <= tx_data;
                sda_out_q <= tx_data[7];
                tx_ack_q  <= 1'b1;
                state_q   <= ST_TX_DATA;
              end else begin
                sda_out_q <= 1'b1;
                state_q   <= ST_WAIT_STOP;
              end
            end
          end
          ST_WAIT_STOP: sda_out_q <= 1'b1;
          default: begin
            sda_out_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sda_out   = sda_out_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ack    = tx_ack_q;
  assign addressed = addressed_q;
  assign state     = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - bus-level bench for i2c_slave with a transaction-level reference model
module tb_i2c_slave;

  localparam int Q = 10;  // clk cycles per quarter SCL period
  localparam logic [6:0] ADDR = 7'h2D;

  logic       clk = 1'b0;
  logic       rst;
  logic       mscl;
  logic       msda;
  logic       sda_bus;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       addressed;
  logic [3:0] state;

  always #5 clk = ~clk;

  assign sda_bus = msda & sda_out;

  i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (mscl),
    .sda_in    (sda_bus),
    .sda_out   (sda_out),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_ack    (tx_ack),
    .addressed (addressed),
    .state     (state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int rx_pulses = 0;
  int tx_pulses = 0;
  int addr_cyc  = 0;

  always @(negedge clk) begin
    if (rx_valid) rx_pulses++;
    if (tx_ack) tx_pulses++;
    if (state == 4'd1) addr_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    msda = 1'b1; tick(Q);
    mscl = 1'b1; tick(Q);
    msda = 1'b0; tick(Q);
    mscl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    msda = 1'b0; tick(Q);
    mscl = 1'b1; tick(Q);
    msda = 1'b1; tick(Q);
  endtask

  task automatic bus_bit(input logic b, output logic got);
    msda = b;    tick(Q);
    mscl = 1'b1; tick(Q);
    got = sda_bus; tick(Q);
    mscl = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], g);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, g);
      b[i] = g;
    end
    bus_bit(mack, g);
  endtask

  initial begin
    logic       ack;
    logic       g;
    logic [7:0] b;
    logic [7:0] rx_model;
    int         base_rx;
    int         base_tx;
    int         base_addr;

    rst = 1'b0; mscl = 1'b1; msda = 1'b1; tx_data = 8'h00;
    tick(5);
    check("rst_sda_out", 32'(sda_out), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ack", 32'(tx_ack), 32'd0);
    check("rst_addressed", 32'(addressed), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b1;
    tick(5);

    // write 0x2D W, data 0xA7
    base_rx = rx_pulses;
    bus_start();
    wr_byte(8'h5A, ack);
    check("w_addr_ack", 32'(ack), 32'd0);
    check("w_addressed", 32'(addressed), 32'd1);
    wr_byte(8'hA7, ack);
    check("w_data_ack", 32'(ack), 32'd0);
    check("w_rx_data", 32'(rx_data), 32'hA7);
    check("w_rx_pulses", 32'(rx_pulses - base_rx), 32'd1);
    check("w_addressed_hold", 32'(addressed), 32'd1);
    bus_stop();
    check("w_stop_state", 32'(state), 32'd0);
    check("w_stop_addressed", 32'(addressed), 32'd0);
    rx_model = 8'hA7;

    // foreign address: silent until STOP
    base_rx = rx_pulses;
    bus_start();
    wr_byte(8'h60, ack);
    check("na_addr_ack", 32'(ack), 32'd1);
    check("na_state", 32'(state), 32'd7);
    wr_byte(8'h55, ack);
    check("na_data_ack", 32'(ack), 32'd1);
    check("na_rx_pulses", 32'(rx_pulses - base_rx), 32'd0);
    bus_stop();
    check("na_stop_state", 32'(state), 32'd0);

    // read 0x3C, ACK, 0xC1, NACK
    base_tx = tx_pulses;
    tx_data = 8'h3C;
    bus_start();
    wr_byte(8'h5B, ack);
    check("r_addr_ack", 32'(ack), 32'd0);
    tx_data = 8'hC1;
    rd_byte(1'b0, b);
    check("r_byte0", 32'(b), 32'h3C);
    rd_byte(1'b1, b);
    check("r_byte1", 32'(b), 32'hC1);
    check("r_tx_pulses", 32'(tx_pulses - base_tx), 32'd2);
    check("r_nack_state", 32'(state), 32'd7);
    bus_stop();
    check("r_stop_state", 32'(state), 32'd0);

    // write 0x11, repeated START, read
    bus_start();
    wr_byte(8'h5A, ack);
    wr_byte(8'h11, ack);
    check("rs_rx_data", 32'(rx_data), 32'h11);
    check("rs_addressed_before", 32'(addressed), 32'd1);
    rx_model = 8'h11;
    bus_start();
    check("rs_addressed_cleared", 32'(addressed), 32'd0);
    check("rs_state_addr", 32'(state), 32'd1);
    tx_data = 8'h96;
    wr_byte(8'h5B, ack);
    check("rs_addr_ack", 32'(ack), 32'd0);
    rd_byte(1'b1, b);
    check("rs_read", 32'(b), 32'h96);
    bus_stop();

    // reset while the 4th data bit of a read is on the bus
    tx_data = 8'hE5;
    bus_start();
    wr_byte(8'h5B, ack);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, g);
    msda = 1'b1; tick(Q);
    mscl = 1'b1; tick(Q);
    check("mr_bit4_low", 32'(sda_out), 32'd0);
    rst = 1'b0;
    tick(1);
    check("mr_sda_released", 32'(sda_out), 32'd1);
    check("mr_state_idle", 32'(state), 32'd0);
    rst = 1'b1;
    tick(Q);
    bus_start();
    wr_byte(8'h5A, ack);
    check("mr_addr_ack", 32'(ack), 32'd0);
    b = 8'($urandom);
    wr_byte(b, ack);
    check("mr_data_ack", 32'(ack), 32'd0);
    check("mr_rx_data", 32'(rx_data), 32'(b));
    rx_model = b;
    bus_stop();

    // randomized transactions against the frame-level model
    for (int t = 0; t < 8; t++) begin
      logic       is_read;
      logic [6:0] a7;
      logic       match;
      int         n;
      logic [7:0] txq [4];

      is_read = 1'($urandom_range(0, 1));
      a7 = ($urandom_range(0, 1) != 0) ? ADDR : 7'($urandom_range(0, 127));
      match = (a7 == ADDR);
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) txq[k] = 8'($urandom);
      base_rx = rx_pulses;
      base_tx = tx_pulses;
      tx_data = txq[0];
      bus_start();
      wr_byte({a7, is_read}, ack);
      check("rnd_addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
      check("rnd_addressed", 32'(addressed), 32'(match));
      if (!is_read) begin
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          wr_byte(b, ack);
          check("rnd_wr_ack", 32'(ack), match ? 32'd0 : 32'd1);
          if (match) rx_model = b;
        end
        check("rnd_rx_data", 32'(rx_data), 32'(rx_model));
        check("rnd_rx_pulses", 32'(rx_pulses - base_rx), match ? 32'(n) : 32'd0);
      end else begin
        for (int k = 0; k < n; k++) begin
          tx_data = txq[k + 1];
          rd_byte((k == n - 1) ? 1'b1 : 1'b0, b);
          check("rnd_rd_byte", 32'(b), match ? 32'(txq[k]) : 32'hFF);
        end
        check("rnd_tx_pulses", 32'(tx_pulses - base_tx), match ? 32'(n) : 32'd0);
        check("rnd_rd_end_state", 32'(state), 32'd7);
      end
      bus_stop();
      check("rnd_stop_state", 32'(state), 32'd0);
      check("rnd_stop_addressed", 32'(addressed), 32'd0);
    end

    // one-clk SDA low pulse while SCL is high
    base_addr = addr_cyc;
    msda = 1'b0;
    tick(1);
    msda = 1'b1;
    tick(20);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    check("glitch_no_start", 32'(addr_cyc - base_addr), 32'd0);
`else
    check("glitch_start_seen", 32'(addr_cyc > base_addr), 32'd1);
`endif
    check("glitch_final_state", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
